// File: rtl/zynet_sequencer.sv
// rtl/zynet_sequencer.sv - zyNet front-end frame sequencer
//
// Purpose: collects one input frame from an upstream valid/ready stream into a
// local buffer, then streams it contiguously into the network behind a
// one-cycle start pulse. It captures the network result vector and presents it
// downstream with valid/yumi. A watchdog bounds the network latency, and a
// counter tracks completed frames.
//
// Optional feature: define ZYNET_SEQ_ARGMAX_EN to add class_o. This output is
// the index of the largest signed result word, with ties going to the lowest
// index. It is registered together with data_o.
//
// Ports:
//   clk_i, reset_n_i     clock, asynchronous active-low reset
//   in_valid_i/in_ready_o/in_data_i   upstream sample stream
//   net_start_o, net_data_o           frame start pulse and sample stream to network
//   net_valid_i, net_data_i, net_yumi_o   network result vector and its acknowledge
//   valid_o, data_o, yumi_i           captured result to downstream
//   busy_o       high unless in LOAD with no samples collected
//   err_o        sticky watchdog error, cleared by clear_err_i
//   frame_count_o  completed downstream handshakes, wraps
//   class_o      (ZYNET_SEQ_ARGMAX_EN only) argmax of captured result

module zynet_sequencer #(
    parameter int WORD_SIZE      = 16,
    parameter int FRAME_LEN      = 32,
    parameter int NUM_OUTPUTS    = 5,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                             clk_i,
    input  logic                             reset_n_i,
    input  logic                             in_valid_i,
    output logic                             in_ready_o,
    input  logic [WORD_SIZE-1:0]             in_data_i,
    output logic                             net_start_o,
    output logic [WORD_SIZE-1:0]             net_data_o,
    input  logic                             net_valid_i,
    input  logic [NUM_OUTPUTS*WORD_SIZE-1:0] net_data_i,
    output logic                             net_yumi_o,
    output logic                             valid_o,
    output logic [NUM_OUTPUTS*WORD_SIZE-1:0] data_o,
    input  logic                             yumi_i,
    output logic                             busy_o,
    output logic                             err_o,
    input  logic                             clear_err_i,
    output logic [CNT_WIDTH-1:0]             frame_count_o
`ifdef ZYNET_SEQ_ARGMAX_EN
    ,
    output logic [$clog2(NUM_OUTPUTS)-1:0]   class_o
`endif
);

    localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
    localparam logic [WD_W-1:0]  LAST_WD  = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_STREAM,
        ST_WAIT,
        ST_HOLD,
        ST_ERR
    } state_t;

    state_t                           state_q, state_d;
    logic [IDX_W-1:0]                 cnt_q, cnt_d;
    logic [WD_W-1:0]                  wdog_q, wdog_d;
    logic [WORD_SIZE-1:0]             buf_q [FRAME_LEN];
    logic [WORD_SIZE-1:0]             buf_d [FRAME_LEN];
    logic                             in_ready_q, in_ready_d;
    logic                             net_start_q, net_start_d;
    logic [WORD_SIZE-1:0]             net_data_q, net_data_d;
    logic                             valid_q, valid_d;
    logic [NUM_OUTPUTS*WORD_SIZE-1:0] data_q, data_d;
    logic                             err_q, err_d;
    logic [CNT_WIDTH-1:0]             frame_cnt_q, frame_cnt_d;
    logic [IDX_W-1:0]                 cnt_inc;
    logic                             accept;

    assign cnt_inc = cnt_q + 1'b1;
    // in_ready_q is only ever set for LOAD, so this qualifies the handshake
    // exactly as the upstream side sees it.
    assign accept  = in_valid_i & in_ready_q & (state_q == ST_LOAD);

`ifdef ZYNET_SEQ_ARGMAX_EN
    localparam int CLS_W = $clog2(NUM_OUTPUTS);

    logic [CLS_W-1:0]            class_q, class_d;
    logic [CLS_W-1:0]            best_idx;
    logic signed [WORD_SIZE-1:0] best_val;

    // Strict greater-than keeps the earliest index on ties.
    always_comb begin
        best_idx = '0;
        best_val = $signed(net_data_i[WORD_SIZE-1:0]);
        for (int i = 1; i < NUM_OUTPUTS; i++) begin
            if ($signed(net_data_i[i*WORD_SIZE +: WORD_SIZE]) > best_val) begin
                best_val = $signed(net_data_i[i*WORD_SIZE +: WORD_SIZE]);
                best_idx = CLS_W'(i);
            end
        end
    end

    always_comb begin
        class_d = class_q;
        if (state_q == ST_WAIT && net_valid_i) begin
            class_d = best_idx;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            class_q <= '0;
        end else begin
            class_q <= class_d;
        end
    end

    assign class_o = class_q;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wdog_d      = wdog_q;
        buf_d       = buf_q;
        net_start_d = 1'b0;
        net_data_d  = '0;
        data_d      = data_q;
        err_d       = err_q;
        frame_cnt_d = frame_cnt_q;

        case (state_q)
            ST_LOAD: begin
                if (accept) begin
                    buf_d[cnt_q] = in_data_i;
                    if (cnt_q == LAST_IDX) begin
                        // buffer[0] was written on an earlier beat (FRAME_LEN >= 2),
                        // so the first STREAM word can be registered right now.
                        state_d     = ST_STREAM;
                        cnt_d       = '0;
                        net_start_d = 1'b1;
                        net_data_d  = buf_q[0];
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            ST_STREAM: begin
                // cnt_q is the index currently on net_data_o.
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                    wdog_d  = '0;
                end else begin
                    cnt_d      = cnt_inc;
                    net_data_d = buf_q[cnt_inc];
                end
            end
            ST_WAIT: begin
                if (net_valid_i) begin
                    data_d  = net_data_i;
                    state_d = ST_HOLD;
                end else if (wdog_q == LAST_WD) begin
                    err_d   = 1'b1;
                    state_d = ST_ERR;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            ST_HOLD: begin
                if (yumi_i) begin
                    frame_cnt_d = frame_cnt_q + 1'b1;
                    state_d     = ST_LOAD;
                end
            end
            ST_ERR: begin
                if (clear_err_i) begin
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_LOAD;
                end
            end
            default: begin
                state_d = ST_LOAD;
                cnt_d   = '0;
            end
        endcase

        // Handshake outputs follow the state being entered, so they change
        // on the same edge as the state itself.
        in_ready_d = (state_d == ST_LOAD);
        valid_d    = (state_d == ST_HOLD);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= ST_LOAD;
            cnt_q       <= '0;
            wdog_q      <= '0;
            in_ready_q  <= 1'b0;
            net_start_q <= 1'b0;
            net_data_q  <= '0;
            valid_q     <= 1'b0;
            data_q      <= '0;
            err_q       <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wdog_q      <= wdog_d;
            in_ready_q  <= in_ready_d;
            net_start_q <= net_start_d;
            net_data_q  <= net_data_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            err_q       <= err_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // The buffer needs no reset: a reset clears cnt_q, so stale words are
    // always overwritten before they can be streamed.
    always_ff @(posedge clk_i) begin
        buf_q <= buf_d;
    end

    // Acknowledge is combinational so the network sees it in the valid cycle.
    // In ERR, results are acknowledged and dropped so the network can drain.
    assign net_yumi_o    = net_valid_i & ((state_q == ST_WAIT) | (state_q == ST_ERR));
    assign in_ready_o    = in_ready_q;
    assign net_start_o   = net_start_q;
    assign net_data_o    = net_data_q;
    assign valid_o       = valid_q;
    assign data_o        = data_q;
    assign err_o         = err_q;
    assign frame_count_o = frame_cnt_q;
    assign busy_o        = !((state_q == ST_LOAD) && (cnt_q == '0));

endmodule

// File: tb/tb_zynet_sequencer.sv
// tb/tb_zynet_sequencer.sv - self-checking bench for zynet_sequencer
module tb_zynet_sequencer;

    localparam int W  = 16;
    localparam int FL = 32;
    localparam int NO = 5;
    localparam int TO = 8;
    localparam int CW = 16;

    logic              clk_i = 1'b0;
    logic              reset_n_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [W-1:0]      in_data_i;
    logic              net_start_o;
    logic [W-1:0]      net_data_o;
    logic              net_valid_i;
    logic [NO*W-1:0]   net_data_i;
    logic              net_yumi_o;
    logic              valid_o;
    logic [NO*W-1:0]   data_o;
    logic              yumi_i;
    logic              busy_o;
    logic              err_o;
    logic              clear_err_i;
    logic [CW-1:0]     frame_count_o;
`ifdef ZYNET_SEQ_ARGMAX_EN
    logic [$clog2(NO)-1:0] class_o;
`endif

    always #5 clk_i = ~clk_i;

    zynet_sequencer #(
        .WORD_SIZE(W), .FRAME_LEN(FL), .NUM_OUTPUTS(NO),
        .TIMEOUT_CYCLES(TO), .CNT_WIDTH(CW)
    ) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
        .net_start_o(net_start_o), .net_data_o(net_data_o),
        .net_valid_i(net_valid_i), .net_data_i(net_data_i), .net_yumi_o(net_yumi_o),
        .valid_o(valid_o), .data_o(data_o), .yumi_i(yumi_i),
        .busy_o(busy_o), .err_o(err_o), .clear_err_i(clear_err_i),
        .frame_count_o(frame_count_o)
`ifdef ZYNET_SEQ_ARGMAX_EN
        , .class_o(class_o)
`endif
    );

    int total = 0;
    int bad   = 0;
    logic [W-1:0]    frame [FL];
    int              exp_count = 0;
    logic [NO*W-1:0] exp_data  = '0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NO*W-1:0] pack5(input int a, input int b, input int c,
                                              input int d, input int e);
        logic [W-1:0] w0, w1, w2, w3, w4;
        w0 = W'(a); w1 = W'(b); w2 = W'(c); w3 = W'(d); w4 = W'(e);
        return {w4, w3, w2, w1, w0};
    endfunction

    function automatic logic [NO*W-1:0] rand_vec();
        logic [NO*W-1:0] v;
        for (int i = 0; i < NO; i++) v[i*W +: W] = W'($urandom);
        return v;
    endfunction

`ifdef ZYNET_SEQ_ARGMAX_EN
    function automatic int ref_argmax(input logic [NO*W-1:0] v);
        int best = 0;
        for (int i = 1; i < NO; i++)
            if ($signed(v[i*W +: W]) > $signed(v[best*W +: W])) best = i;
        return best;
    endfunction
`endif

    task automatic fill_frame(input bit randomize_words);
        for (int i = 0; i < FL; i++)
            frame[i] = randomize_words ? W'($urandom) : W'(i + 1);
    endtask

    // Offers the frame and counts the handshakes the upstream side would see.
    task automatic load_frame(input bit gapped);
        int idx = 0;
        int cyc = 0;
        while (idx < FL && cyc < 400) begin
            @(negedge clk_i);
            in_valid_i = gapped ? (cyc % 2 == 0) : 1'b1;
            in_data_i  = in_valid_i ? frame[idx] : W'($urandom);
            if (in_valid_i && in_ready_o) idx++;
            cyc++;
        end
        check("load_accepts", idx, FL);
    endtask

    // Ends on the negedge of the first WAIT cycle.
    task automatic stream_check();
        @(negedge clk_i);
        in_valid_i = 1'b0;
        for (int k = 0; k < FL; k++) begin
            if (k > 0) @(negedge clk_i);
            check("net_start", net_start_o, (k == 0));
            check("net_data", net_data_o, frame[k]);
            check("in_ready_stream", in_ready_o, 0);
        end
        @(negedge clk_i);
        check("net_data_wait", net_data_o, 0);
        check("net_start_wait", net_start_o, 0);
        check("busy_wait", busy_o, 1);
    endtask

    // Starts in WAIT cycle 1; result arrives after lat idle cycles; downstream
    // holds off for hold cycles before taking it.
    task automatic result_phase(input logic [NO*W-1:0] vec, input int lat, input int hold);
        yumi_i = 1'b1;  // downstream yumi outside HOLD must be ignored
        for (int i = 0; i < lat; i++) begin
            if (i > 0) @(negedge clk_i);
            check("yumi_idle_wait", net_yumi_o, 0);
            check("valid_wait", valid_o, 0);
            if (i < lat - 1) continue;
            @(negedge clk_i);
        end
        yumi_i      = 1'b0;
        net_valid_i = 1'b1;
        net_data_i  = vec;
        #1;
        check("net_yumi_pulse", net_yumi_o, 1);
        check("frame_count_wait", frame_count_o, CW'(exp_count));
        @(negedge clk_i);
        net_valid_i = 1'b0;
        net_data_i  = ~vec;
        exp_data    = vec;
        #1;
        check("net_yumi_single", net_yumi_o, 0);
        for (int i = 0; i <= hold; i++) begin
            if (i > 0) @(negedge clk_i);
            if (i == hold) yumi_i = 1'b1;
            check("valid_hold", valid_o, 1);
            check("data_hold", data_o, exp_data);
            check("in_ready_hold", in_ready_o, 0);
            check("count_hold", frame_count_o, CW'(exp_count));
`ifdef ZYNET_SEQ_ARGMAX_EN
            check("class_hold", class_o, ref_argmax(exp_data));
`endif
        end
        @(negedge clk_i);
        yumi_i = 1'b0;
        exp_count++;
        check("valid_after", valid_o, 0);
        check("count_after", frame_count_o, CW'(exp_count));
        check("in_ready_load", in_ready_o, 1);
        check("busy_load", busy_o, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        reset_n_i   = 1'b0;
        in_valid_i  = 1'b0;
        in_data_i   = '0;
        net_valid_i = 1'b0;
        net_data_i  = '0;
        yumi_i      = 1'b0;
        clear_err_i = 1'b0;
        repeat (2) @(negedge clk_i);
        check("rst_in_ready", in_ready_o, 0);
        check("rst_net_start", net_start_o, 0);
        check("rst_net_data", net_data_o, 0);
        check("rst_net_yumi", net_yumi_o, 0);
        check("rst_valid", valid_o, 0);
        check("rst_data", data_o, 0);
        check("rst_err", err_o, 0);
        check("rst_count", frame_count_o, 0);
        check("rst_busy", busy_o, 0);
        reset_n_i = 1'b1;
        @(negedge clk_i);
        check("in_ready_after_rst", in_ready_o, 1);

        // Contiguous incrementing frame, directed result
        fill_frame(1'b0);
        load_frame(1'b0);
        stream_check();
        result_phase(pack5(3, -2, 7, 0, 1), 2, 5);

        // Network result offered in LOAD is neither acked nor taken
        net_valid_i = 1'b1;
        net_data_i  = rand_vec();
        #1;
        check("yumi_in_load", net_yumi_o, 0);
        @(negedge clk_i);
        net_valid_i = 1'b0;
        check("data_kept_load", data_o, exp_data);

        // Gapped load; result coincides with the last watchdog cycle
        load_frame(1'b1);
        stream_check();
        result_phase(rand_vec(), TO - 1, $urandom_range(0, 4));

        // Watchdog timeout, late result drained, error cleared
        fill_frame(1'b1);
        load_frame(1'b0);
        stream_check();
        for (int i = 1; i <= TO; i++) begin
            if (i > 1) @(negedge clk_i);
            check("err_in_wait", err_o, 0);
        end
        @(negedge clk_i);
        check("err_set", err_o, 1);
        check("busy_err", busy_o, 1);
        check("in_ready_err", in_ready_o, 0);
        net_valid_i = 1'b1;
        net_data_i  = rand_vec();
        #1;
        check("yumi_err_drain", net_yumi_o, 1);
        @(negedge clk_i);
        net_valid_i = 1'b0;
        check("err_sticky", err_o, 1);
        check("valid_err", valid_o, 0);
        check("data_not_taken", data_o, exp_data);
        clear_err_i = 1'b1;
        @(negedge clk_i);
        clear_err_i = 1'b0;
        check("err_cleared", err_o, 0);
        check("in_ready_clear", in_ready_o, 1);
        check("count_after_err", frame_count_o, CW'(exp_count));

        // Reset mid-STREAM
        fill_frame(1'b1);
        load_frame(1'b0);
        @(negedge clk_i);
        in_valid_i = 1'b0;
        repeat (10) @(negedge clk_i);
        check("stream_word10", net_data_o, frame[10]);
        reset_n_i = 1'b0;
        #1;
        check("mid_rst_net_data", net_data_o, 0);
        check("mid_rst_net_start", net_start_o, 0);
        check("mid_rst_in_ready", in_ready_o, 0);
        check("mid_rst_data", data_o, 0);
        check("mid_rst_count", frame_count_o, 0);
        check("mid_rst_busy", busy_o, 0);
        exp_count = 0;
        exp_data  = '0;
        @(negedge clk_i);
        reset_n_i = 1'b1;
        fill_frame(1'b1);
        load_frame(1'b0);
        stream_check();
        result_phase(pack5(5, 9, 9, -1, 0), 0, 1);
`ifdef ZYNET_SEQ_ARGMAX_EN
        check("class_tie_directed", ref_argmax(pack5(5, 9, 9, -1, 0)), 1);
`endif

        // Randomized frames
        for (int f = 0; f < 4; f++) begin
            fill_frame(1'b1);
            load_frame(1'($urandom_range(0, 1)));
            stream_check();
            result_phase(rand_vec(), $urandom_range(0, TO - 1), $urandom_range(0, 4));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
